imem_prefetch: RTL and testbench



---
 rtl/arvi_prefetch_pkg.sv | 21 ++
 rtl/prefetch_fifo.sv | 53 +++++
 rtl/imem_prefetch.sv | 178 +++++++++++++++++
 tb/tb_imem_prefetch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_prefetch_pkg.sv
// Shared types for the instruction prefetcher:
// FSM states and the outstanding-request record.
package arvi_prefetch_pkg;

  localparam int unsigned PF_XLEN    = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    RESP
  } pf_state_t;

  typedef struct packed {
    logic               valid;
    logic [PF_XLEN-1:0] addr;
    logic               demand;
    logic               stale;
  } pf_outst_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Word FIFO holding sequentially prefetched instructions.
// Clear wins over push; pop of an empty FIFO is ignored.
module prefetch_fifo
  import arvi_prefetch_pkg::*;
#(
  parameter  int unsigned XLEN  = PF_XLEN,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic [CW-1:0]   o_count,
  output logic            o_full,
  output logic            o_empty
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push;
  logic            do_pop;

  assign o_full  = cnt_q == CW'(DEPTH);
  assign o_empty = cnt_q == '0;
  assign o_count = cnt_q;
  assign o_rdata = mem_q[rd_q];
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_clear) mem_q[wr_q] <= i_wdata;
  end

endmodule

// File: rtl/imem_prefetch.sv
// Refill-side prefetcher: serves cache word requests from a
// sequential prefetch FIFO, one memory request in flight.
module imem_prefetch
  import arvi_prefetch_pkg::*;
#(
  parameter int unsigned XLEN        = PF_XLEN,
  parameter int unsigned DEPTH       = 4,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] o_data,
  output logic            o_ready,
  input  logic            i_flush,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_mem_ready,
  output logic            o_hit
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] WB = XLEN'(WORD_BYTES);

  pf_state_t       state_q, state_d;
  pf_outst_t       outst_q, outst_d;
  logic            stream_q, stream_d;
  logic            dpend_q, dpend_d;
  logic            ready_q, ready_d;
  logic            hit_q, hit_d;
  logic [XLEN-1:0] head_q, head_d;
  logic [XLEN-1:0] daddr_q, daddr_d;
  logic [XLEN-1:0] data_q, data_d;

  logic [XLEN-1:0] addr_a;
  logic [XLEN-1:0] next_pf;
  logic [XLEN-1:0] fifo_rdata;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_full, fifo_empty;
  logic            push, pop, clr;
  logic            mem_done, pf_live;

  assign addr_a   = i_addr & ~XLEN'(WORD_BYTES - 1);
  assign mem_done = outst_q.valid && i_mem_ready;
  assign pf_live  = outst_q.valid && !outst_q.stale
                 && !outst_q.demand;
  assign next_pf  = head_q + WB * (XLEN'(fifo_cnt)
                 + XLEN'(pf_live));

  prefetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_clear (clr),
    .i_wdata (i_mem_data),
    .o_rdata (fifo_rdata),
    .o_count (fifo_cnt),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    outst_d  = outst_q;
    stream_d = stream_q;
    head_d   = head_q;
    dpend_d  = dpend_q;
    daddr_d  = daddr_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    hit_d    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    if (state_q == RESP) state_d = IDLE;
    if (mem_done) outst_d.valid = 1'b0;
    if (i_flush) begin
      clr      = 1'b1;
      stream_d = 1'b0;
      if (outst_q.valid) outst_d.stale = 1'b1;
      // a killed demand is refetched once the bus drains
      if (outst_q.valid && outst_q.demand) dpend_d = 1'b1;
    end else begin
      if (mem_done && !outst_q.stale) begin
        if (outst_q.demand) begin
          data_d  = i_mem_data;
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          push = 1'b1;
        end
      end
      if (state_q == IDLE && i_req) begin
        if (!fifo_empty && addr_a == head_q) begin
          pop     = 1'b1;
          data_d  = fifo_rdata;
          ready_d = 1'b1;
          hit_d   = 1'b1;
          head_d  = head_q + WB;
          state_d = RESP;
        end else if (pf_live && outst_q.addr == addr_a) begin
          clr     = 1'b1;
          head_d  = addr_a + WB;
          daddr_d = addr_a;
          if (mem_done) begin
            data_d  = i_mem_data;
            ready_d = 1'b1;
            state_d = RESP;
          end else begin
            outst_d.demand = 1'b1;
            state_d        = WAIT_MEM;
          end
        end else begin
          clr      = 1'b1;
          stream_d = 1'b1;
          head_d   = addr_a + WB;
          daddr_d  = addr_a;
          state_d  = WAIT_MEM;
          if (outst_q.valid) begin
            outst_d.stale = 1'b1;
            dpend_d       = 1'b1;
          end else begin
            outst_d = '{valid: 1'b1, addr: addr_a,
                        demand: 1'b1, stale: 1'b0};
          end
        end
      end
      if (!outst_q.valid) begin
        if (dpend_q) begin
          outst_d = '{valid: 1'b1, addr: daddr_q,
                      demand: 1'b1, stale: 1'b0};
          dpend_d = 1'b0;
        end else if (PREFETCH_EN && stream_q && !fifo_full
                     && !outst_d.valid && !dpend_d) begin
          outst_d = '{valid: 1'b1, addr: next_pf,
                      demand: 1'b0, stale: 1'b0};
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      outst_q  <= '0;
      stream_q <= 1'b0;
      dpend_q  <= 1'b0;
      ready_q  <= 1'b0;
      hit_q    <= 1'b0;
      head_q   <= '0;
      daddr_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      outst_q  <= outst_d;
      stream_q <= stream_d;
      dpend_q  <= dpend_d;
      ready_q  <= ready_d;
      hit_q    <= hit_d;
      head_q   <= head_d;
      daddr_q  <= daddr_d;
      data_q   <= data_d;
    end
  end

  assign o_data     = data_q;
  assign o_ready    = ready_q;
  assign o_hit      = hit_q;
  assign o_mem_req  = outst_q.valid;
  assign o_mem_addr = outst_q.addr;

endmodule

// File: tb/tb_imem_prefetch.sv
// Bench for imem_prefetch: directed scenarios plus a random
// request stream checked against an address-keyed memory model.
module tb_imem_prefetch;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_flush = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic        i_mem_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_ready;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_hit;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] bus_q[$];
  bit          seen[logic [31:0]];
  int          mem_lat     = 3;
  bit          rand_lat    = 1'b0;
  bit          mem_en      = 1'b1;
  bit          force_ready = 1'b0;

  imem_prefetch #(
    .XLEN        (32),
    .DEPTH       (4),
    .PREFETCH_EN (1'b1)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .o_data      (o_data),
    .o_ready     (o_ready),
    .i_flush     (i_flush),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_data  (i_mem_data),
    .i_mem_ready (i_mem_ready),
    .o_hit       (o_hit)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a - 32'h100) * 32'h0100_0193 + 32'h13;
  endfunction

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h",
                  tag, got, exp);
  endtask

  // memory: answers after a fixed or random latency
  initial begin : mem_model
    int cnt;
    int lat;
    cnt = 0;
    lat = 1;
    forever begin
      @(negedge i_clk);
      i_mem_ready = 1'b0;
      if (!mem_en) begin
        cnt         = 0;
        i_mem_ready = force_ready;
        i_mem_data  = 32'hDEAD_BEEF;
      end else if (o_mem_req) begin
        if (cnt == 0)
          lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        cnt++;
        if (cnt >= lat) begin
          i_mem_ready = 1'b1;
          i_mem_data  = memw(o_mem_addr);
          bus_q.push_back(o_mem_addr);
          seen[o_mem_addr] = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_req   = 1'b0;
    i_flush = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    bus_q.delete();
    seen.delete();
  endtask

  task automatic fetch(input  logic [31:0] a,
                       output logic [31:0] d,
                       output logic        h,
                       output int          lat);
    d   = '0;
    h   = 1'b0;
    lat = 0;
    @(negedge i_clk);
    i_req  = 1'b1;
    i_addr = a;
    for (int k = 1; k <= 300; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        d   = o_data;
        h   = o_hit;
        lat = k;
        break;
      end
    end
    i_req = 1'b0;
    check_eq("fetch_done", 32'(lat != 0), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    logic        h;
    int          lat;
    int          idx;
    int          hi;
    int          hits;
    logic [31:0] a;

    repeat (3) @(negedge i_clk);
    check_eq("rst_ready", 32'(o_ready), 0);
    check_eq("rst_data", o_data, 0);
    check_eq("rst_mreq", 32'(o_mem_req), 0);
    check_eq("rst_maddr", o_mem_addr, 0);
    check_eq("rst_hit", 32'(o_hit), 0);
    i_rst = 1'b0;

    // cold miss, then the stream fills the FIFO
    mem_lat = 3;
    fetch(32'h100, d, h, lat);
    check_eq("cold_data", d, 32'h13);
    check_eq("cold_hit", 32'(h), 0);
    check_eq("cold_lat", 32'(lat), 4);
    wait_cyc(40);
    check_eq("fill_n", 32'(bus_q.size()), 5);
    for (int i = 0; i < 5 && i < bus_q.size(); i++)
      check_eq("fill_addr", bus_q[i], 32'h100 + 32'(4 * i));
    hi = 0;
    repeat (10) begin
      @(negedge i_clk);
      hi += int'(o_mem_req);
    end
    check_eq("fill_idle", 32'(hi), 0);

    // sequential hit
    fetch(32'h104, d, h, lat);
    check_eq("hit_data", d, memw(32'h104));
    check_eq("hit_hit", 32'(h), 1);
    check_eq("hit_lat", 32'(lat), 1);
    wait_cyc(20);
    check_eq("hit_nbus", 32'(bus_q.size()), 6);
    if (bus_q.size() > 5)
      check_eq("hit_next_pf", bus_q[5], 32'h114);

    // flush in idle empties a full FIFO
    @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    fetch(32'h108, d, h, lat);
    check_eq("fl_idle_hit", 32'(h), 0);
    check_eq("fl_idle_data", d, memw(32'h108));

    // redirect while 0x10C prefetch is on the bus
    do_reset();
    fetch(32'h100, d, h, lat);
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      if (o_mem_req && o_mem_addr == 32'h10C) begin
        hi = 1;
        break;
      end
    end
    check_eq("redir_seen", 32'(hi), 1);
    idx = bus_q.size();
    fetch(32'h200, d, h, lat);
    check_eq("redir_data", d, memw(32'h200));
    check_eq("redir_hit", 32'(h), 0);
    check_eq("redir_nbus", 32'(bus_q.size() >= idx + 2), 1);
    if (bus_q.size() >= idx + 2) begin
      check_eq("redir_drop", bus_q[idx], 32'h10C);
      check_eq("redir_addr", bus_q[idx+1], 32'h200);
    end
    fetch(32'h108, d, h, lat);
    check_eq("redir_fifo", 32'(h), 0);
    check_eq("redir_d108", d, memw(32'h108));

    // flush during the demand for 0x300
    do_reset();
    mem_lat = 6;
    fork
      fetch(32'h300, d, h, lat);
      begin
        repeat (3) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
      end
    join
    check_eq("flw_data", d, memw(32'h300));
    check_eq("flw_hit", 32'(h), 0);
    check_eq("flw_lat", 32'(lat), 14);
    check_eq("flw_nbus", 32'(bus_q.size()), 2);
    if (bus_q.size() >= 2) begin
      check_eq("flw_a0", bus_q[0], 32'h300);
      check_eq("flw_a1", bus_q[1], 32'h300);
    end

    // wrap of the prefetch address
    do_reset();
    mem_lat = 2;
    fetch(32'hFFFF_FFFC, d, h, lat);
    check_eq("wrap_data", d, memw(32'hFFFF_FFFC));
    wait_cyc(6);
    check_eq("wrap_nbus", 32'(bus_q.size() >= 2), 1);
    if (bus_q.size() >= 2)
      check_eq("wrap_pf", bus_q[1], 32'h0);

    // reset in the middle of a miss
    mem_en = 1'b0;
    @(negedge i_clk);
    i_req  = 1'b1;
    i_addr = 32'h400;
    repeat (2) @(negedge i_clk);
    check_eq("rmid_req", 32'(o_mem_req), 1);
    i_rst = 1'b1;
    i_req = 1'b0;
    @(negedge i_clk);
    check_eq("rmid_mreq", 32'(o_mem_req), 0);
    check_eq("rmid_maddr", o_mem_addr, 0);
    check_eq("rmid_ready", 32'(o_ready), 0);
    check_eq("rmid_data", o_data, 0);
    check_eq("rmid_hit", 32'(o_hit), 0);
    i_rst       = 1'b0;
    force_ready = 1'b1;
    @(negedge i_clk);
    force_ready = 1'b0;
    @(negedge i_clk);
    check_eq("late_ready", 32'(o_ready), 0);
    check_eq("late_mreq", 32'(o_mem_req), 0);
    bus_q.delete();
    seen.delete();
    mem_en = 1'b1;
    fetch(32'h500, d, h, lat);
    check_eq("post_rst_data", d, memw(32'h500));

    // random stream, mostly sequential
    do_reset();
    rand_lat = 1'b1;
    a    = 32'h1000;
    hits = 0;
    repeat (120) begin
      if ($urandom_range(0, 9) < 7) a = a + 32'h4;
      else a = 32'h1000 + ($urandom_range(0, 63) << 2);
      wait_cyc(int'($urandom_range(0, 6)));
      fetch(a | 32'($urandom_range(0, 3)), d, h, lat);
      check_eq("rnd_data", d, memw(a));
      if (h) begin
        hits++;
        check_eq("rnd_hit_lat", 32'(lat), 1);
        check_eq("rnd_hit_src", 32'(seen.exists(a)), 1);
      end
    end
    check_eq("rnd_hits", 32'(hits > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
